ddr_wr_burst_master: RTL and testbench

- Upstream feeder for the DDR4 EMIF Avalon-MM port (ctrl_amm_0) in the FDAS DDR controller path.
- Accepts a 512-bit valid/ready data stream, buffers it in a FIFO and issues fixed-length Avalon-MM write bursts to a contiguous DDR region.
- Each job is defined by a base word address and a burst count; completion is signalled with a one-cycle done pulse.
- Runs in the EMIF user clock domain.

---
 rtl/fdas_ddr_pkg.sv | 19 +
 rtl/ddr_wr_fifo.sv | 58 +++++
 rtl/ddr_wr_burst_master.sv | 164 ++++++++++++++++
 tb/tb_ddr_wr_burst_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdas_ddr_pkg.sv
// rtl/fdas_ddr_pkg.sv - shared DDR4 EMIF write-path widths and FSM state type
// Contents:
//   DDR_DATA_W / DDR_ADDR_W / DDR_BCNT_W / DDR_BE_W : Avalon-MM port geometry
//   wr_state_t                                      : burst master FSM states
package fdas_ddr_pkg;

    localparam int DDR_DATA_W = 512;
    localparam int DDR_ADDR_W = 27;
    localparam int DDR_BCNT_W = 7;
    localparam int DDR_BE_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_BURST,
        ST_DONE
    } wr_state_t;

endpackage

// File: rtl/ddr_wr_fifo.sv
// rtl/ddr_wr_fifo.sv - show-ahead data FIFO with occupancy count
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (flushes pointers/count)
//   push, wdata    : write strobe and data; ignored when full
//   pop            : advance read pointer; ignored when empty
//   rdata          : current head entry, valid whenever count != 0
//   count, full    : occupancy (0..DEPTH) and full flag
module ddr_wr_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rptr];

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_wr_burst_master.sv
// rtl/ddr_wr_burst_master.sv - stream-to-Avalon-MM fixed-length write burst master
// Ports:
//   clk, rst                      : EMIF user clock, asynchronous active-high reset
//   cal_success                   : EMIF calibrated; gates the start of every burst
//   start, base_addr, num_bursts  : job request, sampled only when idle
//   busy, done                    : job in progress, one-cycle completion pulse
//   s_valid, s_ready, s_data      : input data stream
//   amm_ready .. amm_byteenable   : Avalon-MM write master towards the EMIF
module ddr_wr_burst_master
    import fdas_ddr_pkg::*;
#(
    parameter int DATA_W     = DDR_DATA_W,
    parameter int ADDR_W     = DDR_ADDR_W,
    parameter int BCNT_W     = DDR_BCNT_W,
    parameter int BURST_LEN  = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int NBURST_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cal_success,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [NBURST_W-1:0] num_bursts,
    output logic                busy,
    output logic                done,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                amm_ready,
    output logic                amm_write,
    output logic [ADDR_W-1:0]   amm_address,
    output logic [BCNT_W-1:0]   amm_burstcount,
    output logic [DATA_W-1:0]   amm_writedata,
    output logic [DATA_W/8-1:0] amm_byteenable
);

    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int TOT_W  = NBURST_W + BEAT_W;

    wr_state_t           state;
    logic [NBURST_W-1:0] nburst_q;
    logic [NBURST_W-1:0] bursts_done;
    logic [TOT_W-1:0]    total_beats;
    logic [TOT_W-1:0]    beats_in;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]   cur_addr;

    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    count_after;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                burst_ready;
    logic                next_ready;
    logic                last_beat;
    logic                last_burst;

    assign s_ready = busy && !fifo_full && (beats_in < total_beats);
    assign push    = s_valid && s_ready;
    assign pop     = amm_write && amm_ready;

    // A burst is only launched with a full burst of data already buffered,
    // so amm_write can stay high until the last beat without checking empty.
    assign burst_ready = cal_success && (fifo_count >= CNT_W'(BURST_LEN));
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign next_ready  = cal_success && (count_after >= CNT_W'(BURST_LEN));
    assign last_beat   = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign last_burst  = ((bursts_done + NBURST_W'(1)) == nburst_q);

    assign amm_address    = cur_addr;
    assign amm_burstcount = BCNT_W'(BURST_LEN);
    assign amm_byteenable = {BE_W{amm_write}};

    ddr_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (amm_writedata),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            amm_write   <= 1'b0;
            nburst_q    <= '0;
            bursts_done <= '0;
            total_beats <= '0;
            beats_in    <= '0;
            beat_cnt    <= '0;
            cur_addr    <= '0;
        end else begin
            done <= 1'b0;
            if (push) begin
                beats_in <= beats_in + TOT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    // busy is still high for the one IDLE cycle after DONE;
                    // a start in that cycle is treated as arriving while busy.
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy        <= 1'b1;
                        nburst_q    <= num_bursts;
                        total_beats <= TOT_W'(num_bursts) * TOT_W'(BURST_LEN);
                        beats_in    <= '0;
                        bursts_done <= '0;
                        beat_cnt    <= '0;
                        cur_addr    <= base_addr;
                        state       <= (num_bursts == '0) ? ST_DONE : ST_WAIT_DATA;
                    end
                end

                ST_WAIT_DATA: begin
                    if (burst_ready) begin
                        amm_write <= 1'b1;
                        state     <= ST_BURST;
                    end
                end

                ST_BURST: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_beat) begin
                            beat_cnt    <= '0;
                            cur_addr    <= cur_addr + ADDR_W'(BURST_LEN);
                            bursts_done <= bursts_done + NBURST_W'(1);
                            if (last_burst) begin
                                amm_write <= 1'b0;
                                state     <= ST_DONE;
                            end else if (!next_ready) begin
                                amm_write <= 1'b0;
                                state     <= ST_WAIT_DATA;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    amm_write <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// tb/tb_ddr_wr_burst_master.sv - directed self-checking bench for ddr_wr_burst_master
module tb_ddr_wr_burst_master;

    localparam int BL = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         cal_success;
    logic         start;
    logic [26:0]  base_addr;
    logic [15:0]  num_bursts;
    logic         busy;
    logic         done;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] s_data;
    logic         amm_ready;
    logic         amm_write;
    logic [26:0]  amm_address;
    logic [6:0]   amm_burstcount;
    logic [511:0] amm_writedata;
    logic [63:0]  amm_byteenable;

    int checks   = 0;
    int failures = 0;

    // bench controls (written by the main sequence only)
    bit src_on   = 0;
    int src_gap  = 0;
    bit rdy_rand = 0;

    // source state
    int src_idx;
    int gap_cnt;

    // monitor state
    int           cyc = 0;
    bit           sfire = 0;
    int           wr_cnt = 0, done_cnt = 0, sfire_cnt = 0, exp_idx = 0;
    int           start_cyc = 0, done_cyc = 0, rise_cyc = 0, beat32_cyc = 0;
    int           first_fire = 0, last_fire = 0, sfire_at_rise = 0;
    bit           rise_seen = 0, prev_stall = 0;
    logic [26:0]  job_base = '0, addr_b0 = '0, addr_b1 = '0, prev_addr = '0, exp_addr;
    logic [511:0] prev_data = '0;

    ddr_wr_burst_master dut (
        .clk            (clk),
        .rst            (rst),
        .cal_success    (cal_success),
        .start          (start),
        .base_addr      (base_addr),
        .num_bursts     (num_bursts),
        .busy           (busy),
        .done           (done),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .amm_ready      (amm_ready),
        .amm_write      (amm_write),
        .amm_address    (amm_address),
        .amm_burstcount (amm_burstcount),
        .amm_writedata  (amm_writedata),
        .amm_byteenable (amm_byteenable)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] make_data(input int idx);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) begin
            d[k*32 +: 32] = {idx[15:0], k[15:0]} ^ 32'hA5A5_0000;
        end
        return d;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stream source: one beat every (src_gap+1) cycles, holds data until accepted
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        src_idx = 0;
        gap_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                src_idx = 0;
                gap_cnt = 0;
            end else if (sfire) begin
                src_idx++;
                gap_cnt = src_gap;
            end else if (gap_cnt != 0) begin
                gap_cnt--;
            end
            s_valid = !rst && src_on && (gap_cnt == 0);
            s_data  = make_data(src_idx);
        end
    end

    // EMIF ready: always ready, or 50% random backpressure
    initial begin
        amm_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            amm_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sfire      = 0;
            wr_cnt     = 0;
            done_cnt   = 0;
            sfire_cnt  = 0;
            exp_idx    = 0;
            rise_seen  = 0;
            prev_stall = 0;
        end else begin
            sfire = s_valid && s_ready;
            if (start && !busy) begin
                wr_cnt    = 0;
                done_cnt  = 0;
                sfire_cnt = 0;
                rise_seen = 0;
                job_base  = base_addr;
                start_cyc = cyc;
            end
            if (prev_stall) begin
                check("hold_write", amm_write, 1);
                check("hold_addr", amm_address, prev_addr);
                check("hold_data", amm_writedata, prev_data);
            end
            if (busy && (wr_cnt % BL) != 0) begin
                check("no_gap", amm_write, 1);
            end
            if (amm_write && !rise_seen) begin
                rise_seen     = 1;
                rise_cyc      = cyc;
                sfire_at_rise = sfire_cnt;
            end
            if (amm_write && amm_ready) begin
                exp_addr = job_base + 27'((wr_cnt / BL) * BL);
                check("wr_addr", amm_address, exp_addr);
                check("wr_data", amm_writedata, make_data(exp_idx));
                check("wr_bcnt", amm_burstcount, BL);
                check("wr_be", amm_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
                if (wr_cnt == 0) begin
                    addr_b0    = amm_address;
                    first_fire = cyc;
                end
                if (wr_cnt == BL) begin
                    addr_b1 = amm_address;
                end
                last_fire = cyc;
                wr_cnt++;
                exp_idx++;
            end
            if (s_valid && s_ready) begin
                sfire_cnt++;
                if (sfire_cnt == BL) begin
                    beat32_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = amm_write && !amm_ready;
            prev_addr  = amm_address;
            prev_data  = amm_writedata;
        end
    end

    task automatic start_job(input logic [26:0] base, input logic [15:0] n);
        @(posedge clk);
        #1;
        base_addr  = base;
        num_bursts = n;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != 0) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, ok, 1);
        @(negedge clk);
        #2;
        check({tag, "_busy_after_done"}, busy, 0);
        repeat (4) @(negedge clk);
        #2;
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_write"}, amm_write, 0);
        check({tag, "_addr"}, amm_address, 0);
        check({tag, "_be"}, amm_byteenable, 0);
        check({tag, "_bcnt"}, amm_burstcount, BL);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cal_success = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_bursts  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic job: continuous stream, no backpressure
        src_on = 1;
        src_gap = 0;
        start_job(27'h100, 16'd2);
        wait_done("basic", 2000);
        check("basic_writes", wr_cnt, 64);
        check("basic_addr_b0", addr_b0, 27'h100);
        check("basic_addr_b1", addr_b1, 27'h120);
        check("basic_back_to_back", last_fire - first_fire, 63);
        check("basic_first_latency", rise_cyc - beat32_cyc, 2);

        // random backpressure
        rdy_rand = 1;
        start_job(27'h200, 16'd2);
        wait_done("bp", 4000);
        check("bp_writes", wr_cnt, 64);
        check("bp_addr_b1", addr_b1, 27'h220);
        rdy_rand = 0;

        // starved stream: one beat every 4 cycles
        src_gap = 3;
        start_job(27'h300, 16'd2);
        wait_done("starved", 4000);
        check("starved_writes", wr_cnt, 64);
        check("starved_buffered_at_rise", sfire_at_rise, 32);
        check("starved_addr_b1", addr_b1, 27'h320);
        src_gap = 0;

        // address wrap
        start_job(27'h7FFFFE0, 16'd2);
        wait_done("wrap", 2000);
        check("wrap_writes", wr_cnt, 64);
        check("wrap_addr_b0", addr_b0, 27'h7FFFFE0);
        check("wrap_addr_b1", addr_b1, 27'h0000000);

        // zero-length job
        start_job(27'h123, 16'd0);
        wait_done("zero", 50);
        check("zero_done_latency", done_cyc - start_cyc, 2);
        check("zero_writes", wr_cnt, 0);
        check("zero_no_write", rise_seen, 0);

        // start while busy is ignored
        src_on = 0;
        start_job(27'h400, 16'd1);
        repeat (5) @(posedge clk);
        start_job(27'h500, 16'd3);
        src_on = 1;
        wait_done("busy_start", 2000);
        check("busy_start_writes", wr_cnt, 32);
        check("busy_start_addr", addr_b0, 27'h400);

        // no writes until calibration succeeds
        cal_success = 1'b0;
        start_job(27'h600, 16'd1);
        repeat (80) @(negedge clk);
        #2;
        check("cal_low_no_write", rise_seen, 0);
        check("cal_low_buffered", sfire_cnt, 32);
        @(posedge clk);
        #1;
        cal_success = 1'b1;
        wait_done("cal", 500);
        check("cal_writes", wr_cnt, 32);
        check("cal_addr", addr_b0, 27'h600);

        // reset in the middle of the first burst
        start_job(27'h700, 16'd2);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (wr_cnt >= 10) break;
        end
        check("midrst_reached_beat10", wr_cnt, 10);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        start_job(27'h800, 16'd1);
        wait_done("after_rst", 2000);
        check("after_rst_writes", wr_cnt, 32);
        check("after_rst_addr", addr_b0, 27'h800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
